// File: rtl/icache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_REQ = 2'd1,
        REFILL  = 2'd2
    } icache_state_t;

    localparam int WORDS_PER_BLOCK = 4;
    localparam int BLOCK_BITS      = 128;
    localparam int OFFSET_BITS     = 2;

    // Select word[offset] from a 128-bit block (word n lives at bits [32n+31:32n]).
    function automatic logic [31:0] block_word(input logic [BLOCK_BITS-1:0]  blk,
                                               input logic [OFFSET_BITS-1:0] off);
        return blk[{off, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: one combinational read port, one write port.
// Only the valid bits are reset; tag and data contents are don't-care until valid.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 32 - 4 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [BLOCK_BITS-1:0] rd_block,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [BLOCK_BITS-1:0] wr_block
);
    localparam int NUM_BLOCKS = 1 << INDEX_BITS;

    logic [NUM_BLOCKS-1:0]                 valid;
    logic [NUM_BLOCKS-1:0][TAG_BITS-1:0]   tags;
    logic [NUM_BLOCKS-1:0][BLOCK_BITS-1:0] data;

    // Valid bits: cleared by reset, set when a block is filled.
    always_ff @(posedge clk) begin
        if (!rst_n)
            valid <= '0;
        else if (wr_en)
            valid[wr_index] <= 1'b1;
    end

    // Tag and data storage: written on fill, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_block;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_block = data[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache between fetch PC and instruction memory.
// Optional feature macro: ICACHE_PERF_CNT_EN adds HIT_COUNT / MISS_COUNT.
module instruction_cache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           PC,
    output logic [31:0]           INSTRUCTION,
    output logic                  BUSY_WAIT,
    output logic                  MEM_READ,
    output logic [27:0]           MEM_ADDRESS,
    input  logic [BLOCK_BITS-1:0] MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]           HIT_COUNT,
    output logic [31:0]           MISS_COUNT
`endif
);
    localparam int TAG_BITS = 32 - 4 - INDEX_BITS;

    icache_state_t state, state_next;

    logic [INDEX_BITS-1:0]  index;
    logic [TAG_BITS-1:0]    tag;
    logic [OFFSET_BITS-1:0] offset;
    logic                   line_valid;
    logic [TAG_BITS-1:0]    line_tag;
    logic [BLOCK_BITS-1:0]  line_block;
    logic                   hit;
    logic                   busy;
    logic                   mem_rd;
    logic                   fill;

    assign offset = PC[3:2];
    assign index  = PC[4 +: INDEX_BITS];
    assign tag    = PC[31 -: TAG_BITS];

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk      (CLK),
        .rst_n    (RESET),
        .rd_index (index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_block (line_block),
        .wr_en    (fill & RESET),
        .wr_index (index),
        .wr_tag   (tag),
        .wr_block (MEM_READDATA)
    );

    assign hit = line_valid && (line_tag == tag);

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESET)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and raw control outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        mem_rd     = 1'b0;
        fill       = 1'b0;
        case (state)
            IDLE: begin
                if (!hit) begin
                    busy       = 1'b1;
                    state_next = MEM_REQ;
                end
            end
            MEM_REQ: begin
                busy   = 1'b1;
                mem_rd = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    fill       = 1'b1;
                    state_next = REFILL;
                end
            end
            REFILL: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, which also aborts a refill at once.
    assign BUSY_WAIT   = RESET & busy;
    assign MEM_READ    = RESET & mem_rd;
    assign MEM_ADDRESS = MEM_READ ? PC[31:4] : 28'd0;
    assign INSTRUCTION = (RESET && !busy) ? block_word(line_block, offset) : 32'd0;

`ifdef ICACHE_PERF_CNT_EN
    // Hit/miss counters, both free-running and wrapping.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else if (state == IDLE) begin
            if (hit)
                HIT_COUNT <= HIT_COUNT + 32'd1;
            else
                MISS_COUNT <= MISS_COUNT + 32'd1;
        end
    end
`endif

    // Fetch must hold PC while the cache is stalling it.
    pc_stable_a: assert property (@(posedge CLK)
        (RESET && $past(RESET) && $past(BUSY_WAIT)) |-> (PC == $past(PC)));

endmodule
